// File: rtl/frame_rx_pkg.sv
// -----------------------------------------------------------------------------
// frame_rx_pkg
// Shared definitions for the serial frame receiver: the receive FSM state
// encoding and the internal error codes used to select which error pulse
// (if any) a frame produces.
// -----------------------------------------------------------------------------
package frame_rx_pkg;

  // Receive FSM states. IDLE waits for the strobe, DATA shifts payload bits,
  // PAR samples the parity bit, GAP waits for the strobe to drop.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // Per-frame outcome. Exactly one code is produced per frame, which keeps
  // the three error pulses mutually exclusive by construction.
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_PAR  = 2'd1;
  localparam logic [1:0] ERR_FRM  = 2'd2;
  localparam logic [1:0] ERR_OVR  = 2'd3;

endpackage

// File: rtl/frame_rx_fifo.sv
// -----------------------------------------------------------------------------
// frame_rx_fifo
// Synchronous FIFO holding received words. Pointers wrap modulo DEPTH
// (DEPTH must be a power of two, >= 2). The head word is presented
// combinationally and reads as zero while the FIFO is empty.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_push, i_data  write request / word (ignored when full)
//   i_pop           read request (ignored when empty)
//   o_data          head-of-FIFO word (0 when empty)
//   o_full/o_empty  occupancy flags
// -----------------------------------------------------------------------------
module frame_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  logic w_do_push;
  logic w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      // Simultaneous push and pop leaves the count unchanged.
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/frame_rx.sv
// -----------------------------------------------------------------------------
// frame_rx
// Serial frame receiver. While in2 is high, in1 carries DATA_W payload bits
// (LSB first) followed by one even-parity bit. Good frames are pushed into a
// small FIFO; bad, truncated or overflowing frames are dropped with a
// one-cycle error pulse.
//
// Handshake: a word is transferred on a rising edge where out_valid and
// out_ready are both high. out_data holds steady while out_valid is high and
// out_ready is low; out_ready has no effect while out_valid is low.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in1          serial data line
//   in2          frame strobe (high for DATA_W+1 cycles per frame)
//   out_data     head-of-buffer word
//   out_valid    out_data is valid
//   out_ready    consumer accepts the head word
//   par_err      pulse: parity failure, frame dropped
//   frm_err      pulse: strobe dropped mid-frame, frame dropped
//   ovr_err      pulse: good frame dropped because buffer full
//   dbg_state    current receive FSM state (frame_rx_pkg::state_e encoding)
// -----------------------------------------------------------------------------
module frame_rx
  import frame_rx_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in1,
  input  logic              in2,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              par_err,
  output logic              frm_err,
  output logic              ovr_err,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  state_e            r_state;
  state_e            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_next;
  logic [1:0]        w_err;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      par_err <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_shift <= w_shift_next;
      par_err <= (w_err == ERR_PAR);
      frm_err <= (w_err == ERR_FRM);
      ovr_err <= (w_err == ERR_OVR);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift_next = r_shift;
    w_err        = ERR_NONE;
    w_push       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (in2) begin
          // Bits enter at the MSB and move right, so after DATA_W shifts
          // the first (LSB) bit sits at position 0.
          w_shift_next             = '0;
          w_shift_next[DATA_W-1]   = in1;
          w_cnt_next               = CNT_W'(1);
          w_state_next             = (DATA_W == 1) ? ST_PAR : ST_DATA;
        end
      end

      ST_DATA: begin
        if (in2) begin
          w_shift_next = {in1, r_shift[DATA_W-1:1]};
          w_cnt_next   = r_cnt + CNT_W'(1);
          if (r_cnt + CNT_W'(1) == CNT_W'(DATA_W)) begin
            w_state_next = ST_PAR;
          end
        end else begin
          w_err        = ERR_FRM;
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end
      end

      ST_PAR: begin
        if (in2) begin
          // Even parity: payload XOR must equal the parity bit.
          // Fullness alone decides overflow; a pop this cycle does not help.
          if ((^r_shift) != in1) begin
            w_err = ERR_PAR;
          end else if (w_full) begin
            w_err = ERR_OVR;
          end else begin
            w_push = 1'b1;
          end
          w_cnt_next   = '0;
          w_state_next = ST_GAP;
        end else begin
          w_err        = ERR_FRM;
          w_cnt_next   = '0;
          w_state_next = ST_IDLE;
        end
      end

      ST_GAP: begin
        // An overlong strobe is tolerated silently; a low cycle is needed
        // before the next frame can start.
        if (!in2) begin
          w_state_next = ST_IDLE;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output buffer
  // ---------------------------------------------------------------------------
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign dbg_state = r_state;

  frame_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (w_pop),
    .o_data  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_frame_rx
// Directed bench for frame_rx (DATA_W=8, FIFO_DEPTH=2). Inputs change 1 ns
// after each rising edge; outputs are checked at that point or on the
// falling edge. Accepted words are compared against an expected queue.
// -----------------------------------------------------------------------------
module tb_frame_rx;
  import frame_rx_pkg::*;

  localparam int W = 8;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in1 = 1'b0;
  logic         in2 = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         par_err;
  logic         frm_err;
  logic         ovr_err;
  logic [1:0]   dbg_state;

  frame_rx #(.DATA_W(W), .FIFO_DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in1       (in1),
    .in2       (in2),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .par_err   (par_err),
    .frm_err   (frm_err),
    .ovr_err   (ovr_err),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Error pulse counters (a one-cycle pulse adds exactly one).
  int n_par = 0;
  int n_frm = 0;
  int n_ovr = 0;
  always @(negedge clk) begin
    if (par_err) n_par++;
    if (frm_err) n_frm++;
    if (ovr_err) n_ovr++;
  end

  // Scoreboard: every accepted word must match the queue head.
  logic [W-1:0] exp_q[$];
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check("sb_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        check("sb_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive(input logic b, input logic s);
    in1 = b;
    in2 = s;
    @(posedge clk);
    #1;
  endtask

  task automatic send_data(input logic [W-1:0] d);
    for (int i = 0; i < W; i++) drive(d[i], 1'b1);
  endtask

  task automatic send_frame(input logic [W-1:0] d, input logic bad_par);
    send_data(d);
    drive((^d) ^ bad_par, 1'b1);
  endtask

  function automatic int err_total();
    return n_par + n_frm + n_ovr;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [W-1:0] b2b [5] = '{8'h12, 8'h34, 8'hFE, 8'h00, 8'hC3};
  logic [W-1:0] ff_word;
  logic [W-1:0] s81;
  int base;

  initial begin
    // Reset state
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data), 32'd0);
    check("rst_errs",  32'({par_err, frm_err, ovr_err}), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 0xA5, good parity, consumer ready
    out_ready = 1'b1;
    base = err_total();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0);
    check("a5_valid", 32'(out_valid), 32'd1);
    check("a5_data",  32'(out_data), 32'hA5);
    drive(1'b0, 1'b0);
    check("a5_valid_one_cycle", 32'(out_valid), 32'd0);
    check("a5_no_err", 32'(err_total()), 32'(base));

    // 0x3C with wrong parity
    base = n_par;
    send_frame(8'h3C, 1'b1);
    check("3c_par_err", 32'(par_err), 32'd1);
    check("3c_valid",   32'(out_valid), 32'd0);
    drive(1'b0, 1'b0);
    check("3c_par_err_pulse", 32'(par_err), 32'd0);
    check("3c_par_cnt", 32'(n_par), 32'(base + 1));

    // Strobe dropped after 5 data bits, then 0x01
    base = n_frm;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    check("trunc_frm_err", 32'(frm_err), 32'd1);
    check("trunc_state",   32'(dbg_state), 32'(ST_IDLE));
    drive(1'b0, 1'b0);
    check("trunc_frm_cnt", 32'(n_frm), 32'(base + 1));
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b0);
    check("01_valid", 32'(out_valid), 32'd1);
    check("01_data",  32'(out_data), 32'h01);
    drive(1'b0, 1'b0);

    // Overflow: 0x11, 0x22, 0x33 with consumer stalled
    out_ready = 1'b0;
    base = n_ovr;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0);
    drive(1'b0, 1'b0);
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b0);
    drive(1'b0, 1'b0);
    check("ovr_hold_data", 32'(out_data), 32'h11);
    send_frame(8'h33, 1'b0);
    check("ovr_err",   32'(ovr_err), 32'd1);
    check("ovr_valid", 32'(out_valid), 32'd1);
    check("ovr_head",  32'(out_data), 32'h11);
    out_ready = 1'b1;
    drive(1'b0, 1'b0);
    check("ovr_second", 32'(out_data), 32'h22);
    drive(1'b0, 1'b0);
    check("ovr_drained", 32'(out_valid), 32'd0);
    check("ovr_cnt", 32'(n_ovr), 32'(base + 1));

    // Full buffer, pop during the parity bit does not rescue the frame
    out_ready = 1'b0;
    base = n_ovr;
    exp_q.push_back(8'h44);
    send_frame(8'h44, 1'b0);
    drive(1'b0, 1'b0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b0);
    drive(1'b0, 1'b0);
    send_data(8'h66);
    out_ready = 1'b1;
    drive(^(8'h66), 1'b1);
    check("rescue_ovr_err", 32'(ovr_err), 32'd1);
    check("rescue_head",    32'(out_data), 32'h55);
    drive(1'b0, 1'b0);
    check("rescue_drained", 32'(out_valid), 32'd0);
    check("rescue_ovr_cnt", 32'(n_ovr), 32'(base + 1));

    // Overlong strobe: word accepted, no error, back to IDLE after low
    base = err_total();
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    check("long_state_gap", 32'(dbg_state), 32'(ST_GAP));
    drive(1'b0, 1'b0);
    check("long_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("long_no_err", 32'(err_total()), 32'(base));

    // Reset during data bit 4 of 0xFF with a word buffered
    out_ready = 1'b0;
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b0);
    drive(1'b0, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    ff_word = 8'hFF;
    for (int i = 0; i < 4; i++) drive(ff_word[i], 1'b1);
    in1 = ff_word[4];
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_data",  32'(out_data), 32'd0);
    check("mid_rst_errs",  32'({par_err, frm_err, ovr_err}), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    base = err_total();
    in2 = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b0);
    check("5a_valid", 32'(out_valid), 32'd1);
    check("5a_data",  32'(out_data), 32'h5A);
    drive(1'b0, 1'b0);
    check("5a_no_err", 32'(err_total()), 32'(base));

    // Strobe already high when reset releases: frame 0x81
    s81 = 8'h81;
    rst_n = 1'b0;
    in1 = s81[0];
    in2 = 1'b1;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("rel_state", 32'(dbg_state), 32'(ST_DATA));
    exp_q.push_back(8'h81);
    for (int i = 1; i < W; i++) drive(s81[i], 1'b1);
    drive(^s81, 1'b1);
    check("81_data", 32'(out_data), 32'h81);
    drive(1'b0, 1'b0);

    // Back-to-back frames, one idle cycle apart, consumer always ready
    base = err_total();
    for (int f = 0; f < 5; f++) begin
      exp_q.push_back(b2b[f]);
      send_frame(b2b[f], 1'b0);
      check("b2b_valid", 32'(out_valid), 32'd1);
      drive(1'b0, 1'b0);
    end
    check("b2b_no_err", 32'(err_total()), 32'(base));

    repeat (2) @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
